// File: rtl/dadda_arb_pkg.sv
// ---------------------------------------------------------------------------
// dadda_arb_pkg
// Shared types and helpers for the dadda_mul_arbiter block.
//   arb_state_e : FSM encoding (IDLE, HOLD, RESP)
//   PERF_CNT_W  : width of each per-requester grant counter
//   rr_pick     : round-robin search over a zero-padded valid vector
// ---------------------------------------------------------------------------
package dadda_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int PERF_CNT_W = 16;

    // Widest requester count rr_pick can serve.
    localparam int RR_MAX = 32;

    // Returns {found, idx}: the first set bit of valid at or above ptr,
    // wrapping at RR_MAX. Callers zero-pad valid above NREQ, so wrapping at
    // RR_MAX yields the same winner as wrapping at NREQ.
    function automatic logic [5:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                           input logic [4:0]        ptr);
        logic       found;
        logic [4:0] idx;
        logic [4:0] cand;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < RR_MAX; k++) begin
            cand = ptr + 5'(k);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among NREQ requesters.
// Ports:
//   req_valid [NREQ-1:0] in  : per-requester valid
//   rr_ptr    [IDW-1:0]  in  : index searched first
//   grant     [NREQ-1:0] out : one-hot grant (all zero when nothing valid)
//   grant_idx [IDW-1:0]  out : index of the granted requester
//   found                out : at least one requester is valid
// ---------------------------------------------------------------------------
module rr_arbiter
    import dadda_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            found
);

    logic [RR_MAX-1:0] valid_pad;
    logic [4:0]        ptr_pad;
    logic [5:0]        pick;

    always_comb begin
        valid_pad             = '0;
        valid_pad[NREQ-1:0]   = req_valid;
        ptr_pad               = '0;
        ptr_pad[IDW-1:0]      = rr_ptr;
        pick                  = rr_pick(valid_pad, ptr_pad);
        found                 = pick[5];
        grant_idx             = pick[IDW-1:0];
        grant                 = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = pick[5] && (pick[4:0] == 5'(i));
        end
    end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// ---------------------------------------------------------------------------
// dadda_mul_arbiter
// Time-shares one external combinational WIDTH x WIDTH multiplier between
// NREQ requesters. A round-robin winner's operands are registered, held on
// the multiplier inputs for LAT cycles, and the product is returned on a
// single response channel tagged with the requester index.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or 0)
//   req_a, req_b          : packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_in1, mul_in2      : registered operands to the multiplier
//   mul_out, mul_ovf      : multiplier product and overflow
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id, rsp_data,
//   rsp_ovf               : registered response payload
//   busy                  : high whenever the FSM is not IDLE
//
// Optional build macro DADDA_ARB_PERF_CNT_EN adds:
//   cnt_clr   in  : synchronous clear of all grant counters (wins over +1)
//   grant_cnt out : NREQ saturating 16-bit grant counters, packed
// ---------------------------------------------------------------------------
module dadda_mul_arbiter
    import dadda_arb_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int NREQ  = 4,
    parameter int LAT   = 1,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_in1,
    output logic [WIDTH-1:0]        mul_in2,
    input  logic [2*WIDTH-1:0]      mul_out,
    input  logic                    mul_ovf,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    rsp_ovf,
`ifdef DADDA_ARB_PERF_CNT_EN
    input  logic                    cnt_clr,
    output logic [NREQ*PERF_CNT_W-1:0] grant_cnt,
`endif
    output logic                    busy
);

    localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

    arb_state_e           state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                 rsp_ovf_q, rsp_ovf_d;

    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       win_idx;
    logic                 win_found;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (win_idx),
        .found     (win_found)
    );

    // Ready is masked by rst so that every output reads 0 while reset is held,
    // even though the reset state is IDLE.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign mul_in1   = op_a_q;
    assign mul_in2   = op_b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_a_d   = req_a[int'(win_idx)*WIDTH +: WIDTH];
                    op_b_d   = req_b[int'(win_idx)*WIDTH +: WIDTH];
                    id_d     = win_idx;
                    rr_ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
                    cnt_d    = CNTW'(LAT-1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    rsp_data_d = mul_out;
                    rsp_ovf_d  = mul_ovf;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

`ifdef DADDA_ARB_PERF_CNT_EN
    logic [NREQ*PERF_CNT_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < NREQ; i++) begin
            if (cnt_clr) begin
                perf_d[i*PERF_CNT_W +: PERF_CNT_W] = '0;
            end else if (req_ready[i] && req_valid[i] &&
                         perf_q[i*PERF_CNT_W +: PERF_CNT_W] != {PERF_CNT_W{1'b1}}) begin
                perf_d[i*PERF_CNT_W +: PERF_CNT_W] =
                    perf_q[i*PERF_CNT_W +: PERF_CNT_W] + PERF_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign grant_cnt = perf_q;
`endif

endmodule

// File: doc/dadda_mul_arbiter.md
Name: dadda_mul_arbiter

Overview:
- Shares one combinational WIDTH x WIDTH Dadda multiplier (if_multiplier datapath) between NREQ requesters.
- Arbitration is round-robin with a valid/ready handshake on each requester.
- Granted operands are registered, held on the multiplier inputs for LAT cycles, and the product is captured.
- The product is returned on a single response channel tagged with the requester ID.
- Sits between requester logic and the multiplier instance; the multiplier stays purely combinational.

Parameters:
- WIDTH, 6, operand width; the product is 2*WIDTH.
- NREQ, 4, number of requesters; must be >= 1.
- LAT, 1, cycles the operands are held before the product is sampled (settle budget); must be >= 1.
- IDW, $clog2(NREQ) with a minimum of 1, requester ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit is high per cycle.
- req_a  in  NREQ*WIDTH  packed operand A; requester i occupies [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing.
- mul_in1  out  WIDTH  to multiplier in1.
- mul_in2  out  WIDTH  to multiplier in2.
- mul_out  in  2*WIDTH  from multiplier out.
- mul_ovf  in  1  from multiplier overflow.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  2*WIDTH  registered product.
- rsp_ovf  out  1  registered overflow flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr_ptr=0, wait counter=0, operand registers=0. All outputs reset to 0: req_ready, mul_in1/2, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy.
- FSM states: IDLE, HOLD, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally; all other ready bits are 0.
  - On the handshake, in the same clock edge: latch req_a/req_b[winner] into op_a/op_b, latch the ID, set rr_ptr=(winner+1) mod NREQ, load cnt=LAT-1, go to HOLD.
  - If no request is valid, stay in IDLE and leave rr_ptr unchanged.
- HOLD:
  - mul_in1=op_a and mul_in2=op_b, driven from registers (glitch-free).
  - cnt decrements each cycle.
  - When cnt==0, capture rsp_data=mul_out and rsp_ovf=mul_ovf, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_ovf are held stable until rsp_ready=1.
  - On the handshake, go to IDLE; rsp_valid drops the next cycle.
  - req_ready stays all-zero in HOLD and RESP.
- Latency from request accept to rsp_valid: LAT+1 cycles.
- Minimum issue interval: LAT+2 cycles. No overlap, because only one operand set is in flight.
- Requester rule: req_valid and operands stay stable until req_ready. A requester that deasserts before ready is not arbitrated and causes no error.
- Fairness: each valid requester is granted within NREQ grants.
- rr_ptr wraps from NREQ-1 to 0. With NREQ=1, rr_ptr is constantly 0.
- Back-pressure: rsp_ready may stay low indefinitely; the block remains in RESP and grants nothing.
- Reset asserted mid-operation aborts the in-flight operation with no response. The operation is lost and the requester must reissue.
- mul_in1/2 keep their last values in IDLE and RESP (no toggling).

Optional Feature:
- Macro: DADDA_ARB_PERF_CNT_EN.
- Defined:
  - Adds output grant_cnt (NREQ*16 bits) and input cnt_clr (1 bit).
  - One saturating 16-bit counter per requester increments on that requester's request handshake.
  - Counters saturate at 16'hFFFF.
  - cnt_clr=1 clears all counters synchronously; cnt_clr takes priority over an increment in the same cycle.
  - Counters reset to 0 on rst.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Package dadda_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_e {IDLE, HOLD, RESP};
  - the function rr_pick(valid, ptr), returning {found, idx};
  - constant PERF_CNT_W = 16.
- Sub-module rr_arbiter (parameter NREQ): combinational round-robin pick of the one-hot grant and index from req_valid and rr_ptr. The FSM, operand registers and counters stay in the top module.

Test Plan:
- NREQ=4, WIDTH=6, LAT=1; requester 2 sends a=63, b=63 alone -> req_ready[2] high that cycle; rsp_valid 2 cycles later with rsp_data=3969, rsp_id=2.
- All four requesters valid continuously; requester i sends a=i+1, b=10; rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_data equals (id+1)*10; one grant every 3 cycles.
- rsp_ready held low for 5 cycles after rsp_valid -> rsp_data/rsp_id stable and all req_ready bits 0 throughout; after the handshake, the next grant goes to the next requester after the last winner.
- LAT=3, a=5, b=7 -> mul_in1/2 stable for 3 cycles; rsp_valid 4 cycles after accept; rsp_data=35.
- rst pulsed while in HOLD -> all outputs 0 asynchronously, no response emitted; the next grant after reset goes to the lowest valid index (rr_ptr=0).
- With DADDA_ARB_PERF_CNT_EN: 3 grants to requester 1, then cnt_clr=1 together with a grant -> counter goes 3 then 0; a 65537-grant run saturates at 65535.
